pic_inta_sequencer: RTL
=======================

PIC_INTA_SEQUENCER -- requirements
Module: pic_inta_sequencer

Interface
REQ-001 Parameter: none; all widths fixed (8 request lines, 3-bit level index).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 irr  input  8  pending-request vector from the interrupt request register; bit n = IRn.
REQ-005 imr  input  8  mask vector; bit n = 1 masks IRn.
REQ-006 vec_base  input  5  vector bits T7..T3.
REQ-007 aeoi  input  1  1 = automatic EOI mode.
REQ-008 inta_n  input  1  CPU acknowledge strobe, synchronous to clk, active-low.
REQ-009 eoi_req  input  1  one-cycle EOI command pulse.
REQ-010 eoi_specific  input  1  qualifies eoi_req: 1 = specific, 0 = non-specific.
REQ-011 eoi_level  input  3  level cleared by specific EOI.
REQ-012 int_out  output  1  interrupt request to CPU, registered.
REQ-013 isr  output  8  in-service register.
REQ-014 irr_clr  output  1  one-cycle pulse: clear irr bit irr_clr_idx.
REQ-015 irr_clr_idx  output  3  level to clear in irr; held until next ack.
REQ-016 data_out  output  8  vector byte; data_oe  output  1  data_out valid/drive enable.

Function
REQ-017 Priority fixed: IR0 highest, IR7 lowest.
REQ-018 Eligible set = irr & ~imr, restricted to levels strictly higher priority than the highest-priority set isr bit (fully nested); all unmasked levels when isr = 0.
REQ-019 States: IDLE, PEND, ACK1, WAIT2, ACK2.
REQ-020 IDLE -> PEND on rising edge with eligible set nonzero; int_out = 1 from that edge.
REQ-021 PEND -> IDLE if eligible set becomes zero before inta_n falls; int_out = 0 from that edge.
REQ-022 inta_n falling edge = sampled 1 previous cycle, 0 current cycle; inta_n low in IDLE is ignored.
REQ-023 PEND -> ACK1 on first falling edge: latch resolved level L (highest-priority eligible), set isr[L], pulse irr_clr with irr_clr_idx = L, int_out = 0.
REQ-024 Spurious: eligible set zero at first falling edge -> L = 7, isr unchanged, no irr_clr pulse.
REQ-025 ACK1 -> WAIT2 on inta_n rising; WAIT2 -> ACK2 on next inta_n falling edge.
REQ-026 ACK2: data_out = {vec_base, L}, data_oe = 1, registered, from the falling-edge cycle until inta_n sampled high; data_out = 0 and data_oe = 0 otherwise.
REQ-027 ACK2 -> IDLE on inta_n rising; if aeoi = 1 and not spurious, clear isr[L] on that edge.
REQ-028 irr/imr changes during ACK1/WAIT2/ACK2 do not alter latched L.
REQ-029 Non-specific EOI clears highest-priority set isr bit; no effect when isr = 0.
REQ-030 Specific EOI clears isr[eoi_level] only.
REQ-031 EOI accepted in every state; EOI on same edge as set of isr[L]: set applied first, then EOI clear evaluated on updated value.
REQ-032 New request may re-enter PEND in the cycle after return to IDLE; eligibility reevaluated from updated isr.

Reset
REQ-033 rst_n low: state IDLE, isr = 0, int_out = 0, irr_clr = 0, irr_clr_idx = 0, data_out = 0, data_oe = 0, inta_n history = 1.
REQ-034 Reset mid-acknowledge aborts the cycle; no vector driven, no isr bit left set.
REQ-035 Reset release synchronous to clk; first transition possible on first rising edge with rst_n high.

Verification
REQ-036 irr=0x08, imr=0, vec_base=0x11, two INTA pulses -> int_out 1 then 0 at first fall, irr_clr idx 3, isr=0x08, data_out=0x8B while second pulse low.
REQ-037 irr=0x84, isr=0, imr=0x04 -> level 7 served, isr=0x80; then irr=0x04, imr=0 -> int_out reasserts (nested preemption), isr=0x84 after ack.
REQ-038 irr=0x20 then dropped to 0 before first INTA fall -> int_out deasserts, state IDLE; irr=0x20 dropped during PEND with INTA fall same cycle -> vector {vec_base,7}, isr unchanged, no irr_clr.
REQ-039 isr=0x84, non-specific EOI -> isr=0x80; specific EOI level 7 -> isr=0x00.
REQ-040 aeoi=1, irr=0x01, full ack -> isr=0x01 during ack, 0x00 after second INTA rise.
REQ-041 rst_n low during WAIT2 -> all outputs 0 immediately; later INTA pulses ignored.

Source files
------------

// File: rtl/pic_inta_sequencer.sv
// -----------------------------------------------------------------------------
// pic_inta_sequencer
//
// Interrupt-acknowledge sequencer for an 8-level, fixed-priority interrupt
// controller. IR0 has the highest priority and IR7 the lowest. The block does
// four things:
//   - picks the highest-priority pending request. A request is eligible only
//     when it is unmasked and has strictly higher priority than everything
//     currently in service (fully nested).
//   - raises int_out to the CPU.
//   - runs the two-pulse INTA handshake: the first pulse latches the level,
//     the second pulse drives the vector.
//   - maintains the in-service register, including automatic, non-specific
//     and specific EOI.
//
// Ports
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset
//   irr          in   8  pending requests (bit n = IRn)
//   imr          in   8  mask (bit n = 1 masks IRn)
//   vec_base     in   5  vector bits T7..T3
//   aeoi         in   1  automatic EOI mode
//   inta_n       in   1  CPU acknowledge strobe, active-low, sampled on clk
//   eoi_req      in   1  one-cycle EOI command
//   eoi_specific in   1  1 = specific EOI, 0 = non-specific
//   eoi_level    in   3  level cleared by a specific EOI
//   int_out      out  1  interrupt request to CPU (registered)
//   isr          out  8  in-service register
//   irr_clr      out  1  one-cycle pulse: clear irr[irr_clr_idx]
//   irr_clr_idx  out  3  level to clear; held until the next acknowledge
//   data_out     out  8  vector byte {vec_base, level}
//   data_oe      out  1  data_out valid / bus drive enable
//   state_dbg    out  3  current sequencer state (observation only)
//
// Handshake: data_oe acts as a valid flag for data_out. It rises on the edge
// that samples the second falling edge of inta_n. It stays high for as long
// as inta_n is sampled low. It drops on the edge that samples inta_n high
// again. There is no ready: the CPU's strobe alone paces the transfer.
// -----------------------------------------------------------------------------
module pic_inta_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [4:0] vec_base,
  input  logic       aeoi,
  input  logic       inta_n,
  input  logic       eoi_req,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] isr,
  output logic       irr_clr,
  output logic [2:0] irr_clr_idx,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_ACK1  = 3'd2,
    S_WAIT2 = 3'd3,
    S_ACK2  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       inta_prev_q;
  logic [2:0] lvl_q, lvl_d;
  logic       spur_q, spur_d;
  logic [7:0] isr_q, isr_d;
  logic       int_out_q, int_out_d;
  logic       irr_clr_q, irr_clr_d;
  logic [2:0] irr_clr_idx_q, irr_clr_idx_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;

  logic       inta_fall, inta_rise;
  logic [7:0] isr_top, allow, eligible;
  logic       any_elig;
  logic [2:0] res_lvl;
  logic       take_ack, finish_ack;
  logic [7:0] isr_work;

  assign inta_fall = inta_prev_q & ~inta_n;
  assign inta_rise = ~inta_prev_q & inta_n;

  // isr_top isolates the lowest-index (highest-priority) in-service bit.
  // Subtracting one from it gives every strictly higher-priority level.
  assign isr_top  = isr_q & (~isr_q + 8'd1);
  assign allow    = (isr_q == 8'd0) ? 8'hFF : (isr_top - 8'd1);
  assign eligible = irr & ~imr & allow;
  assign any_elig = |eligible;

  // Scan from IR7 down to IR0 so that the last hit, IR0-most, wins.
  always_comb begin
    res_lvl = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) res_lvl = 3'(i);
    end
  end

  assign take_ack   = (state_q == S_PEND) && inta_fall;
  assign finish_ack = (state_q == S_ACK2) && inta_rise;

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      inta_prev_q   <= 1'b1;
      lvl_q         <= 3'd0;
      spur_q        <= 1'b0;
      isr_q         <= 8'd0;
      int_out_q     <= 1'b0;
      irr_clr_q     <= 1'b0;
      irr_clr_idx_q <= 3'd0;
      data_out_q    <= 8'd0;
      data_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      inta_prev_q   <= inta_n;
      lvl_q         <= lvl_d;
      spur_q        <= spur_d;
      isr_q         <= isr_d;
      int_out_q     <= int_out_d;
      irr_clr_q     <= irr_clr_d;
      irr_clr_idx_q <= irr_clr_idx_d;
      data_out_q    <= data_out_d;
      data_oe_q     <= data_oe_d;
    end
  end

  // Next-state logic. In PEND a falling edge of inta_n wins over a vanishing
  // request: once the CPU has started to acknowledge, the cycle must finish,
  // even if it finishes with the spurious vector.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_elig)       state_d = S_PEND;
      S_PEND:  if (inta_fall)      state_d = S_ACK1;
               else if (!any_elig) state_d = S_IDLE;
      S_ACK1:  if (inta_rise)      state_d = S_WAIT2;
      S_WAIT2: if (inta_fall)      state_d = S_ACK2;
      S_ACK2:  if (inta_rise)      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    lvl_d         = lvl_q;
    spur_d        = spur_q;
    irr_clr_d     = 1'b0;
    irr_clr_idx_d = irr_clr_idx_q;
    isr_work      = isr_q;

    if (take_ack) begin
      spur_d = ~any_elig;
      lvl_d  = any_elig ? res_lvl : 3'd7;
      if (any_elig) begin
        isr_work[res_lvl] = 1'b1;
        irr_clr_d         = 1'b1;
        irr_clr_idx_d     = res_lvl;
      end
    end

    if (finish_ack && aeoi && !spur_q) begin
      isr_work[lvl_q] = 1'b0;
    end

    // EOI acts on the value after this edge's set/auto-clear.
    if (eoi_req) begin
      if (eoi_specific) begin
        isr_work[eoi_level] = 1'b0;
      end else begin
        isr_work = isr_work & ~(isr_work & (~isr_work + 8'd1));
      end
    end
    isr_d = isr_work;

    int_out_d  = (state_d == S_PEND);
    data_oe_d  = (state_d == S_ACK2);
    data_out_d = data_oe_d ? {vec_base, lvl_d} : 8'd0;
  end

  assign int_out     = int_out_q;
  assign isr         = isr_q;
  assign irr_clr     = irr_clr_q;
  assign irr_clr_idx = irr_clr_idx_q;
  assign data_out    = data_out_q;
  assign data_oe     = data_oe_q;
  assign state_dbg   = state_q;

endmodule
